dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Accepts one request at a time over a valid/ready handshake, waits a configurable number of wait states, then performs the access on an internal word-organised array.
- Returns the access result over a valid/ready response channel.
- Handles RV32 byte/half/word loads and stores, little-endian, with sign/zero extension and error signalling. It replaces the zero-latency data memory once the pipeline gains memory stall support.

---
 rtl/dmem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port: one request at a time,
// WAIT_CYCLES wait states, then a little-endian RV32 B/H/W access on a word array.
module dmem_responder #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [2:0]        req_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready depends only on the state register; resp_valid holds with
  // stable payload until it is taken.

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  // Access operands: straight from the request port on the accept edge
  // (zero-wait case), otherwise from the latched copy.
  logic              a_we;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_wdata;
  logic [2:0]        a_size;

  always_comb begin
    a_we    = we_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_size  = size_q;
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_size  = req_size;
    end
  end

  logic [AWIDTH-1:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              size_bad;
  logic              misalign;
  logic              acc_err;

  assign word_addr    = {2'b00, a_addr[AWIDTH-1:2]};
  assign word_idx     = a_addr[IDX_W+1:2];
  assign lane         = a_addr[1:0];
  assign out_of_range = (word_addr >= AWIDTH'(DEPTH_WORDS));
  assign size_bad     = (a_size == 3'b011) || (a_size == 3'b110) || (a_size == 3'b111)
                      || (a_we && a_size[2]);
  assign misalign     = ((a_size[1:0] == 2'b01) && a_addr[0])
                      || ((a_size[1:0] == 2'b10) && (lane != 2'b00));
  assign acc_err      = out_of_range || size_bad || misalign;

  logic [DWIDTH-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DWIDTH-1:0] load_data;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{a_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (a_size)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  logic [3:0]        wr_be;
  logic [DWIDTH-1:0] wr_data;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = a_wdata;
    case (a_size[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = a_wdata;
      end
      default: wr_be = 4'b0000;
    endcase
  end

  logic              access_go;
  logic              mem_we;
  logic [DWIDTH-1:0] acc_rdata;

  // A pending store must never land while reset is asserted.
  assign mem_we    = access_go && a_we && !acc_err && !reset;
  assign acc_rdata = (acc_err || a_we) ? '0 : load_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    access_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          if (WAIT_CYCLES == 0) begin
            access_go = 1'b1;
            rdata_d   = acc_rdata;
            err_d     = acc_err;
            state_d   = S_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          access_go = 1'b1;
          rdata_d   = acc_rdata;
          err_d     = acc_err;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed RV32 load/store scenarios plus random
// traffic, checked every cycle against a byte-level reference model.
module tb_dmem_responder;

  localparam int WAITC = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .AWIDTH(32), .DWIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the access rules written directly.
  logic [7:0] mdl_mem [0:4*DEPTH-1];

  function automatic void mdl_exec(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] size,
                                   output logic [31:0] rdata, output logic err);
    int nb;
    logic [31:0] v;
    nb = 1 << size[1:0];
    err = (addr / 4 >= DEPTH) || (size == 3'd3) || (size == 3'd6) || (size == 3'd7)
          || (we && size >= 3'd4) || (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mdl_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl_mem[addr + i];
      if (!size[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
    end
  endfunction

  // Cycle-level expectation: an accept in cycle t performs the access at the
  // end of cycle t+WAITC and shows the response from cycle t+1+WAITC.
  bit          pending = 1'b0;
  bit          committed = 1'b0;
  int          cyc = 0;
  int          acc_c = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_size;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  bit          mon_ev;

  always @(posedge clk) begin
    if (reset) begin
      pending   = 1'b0;
      committed = 1'b0;
    end else begin
      if (pending && committed && cyc >= acc_c + 1 + WAITC && resp_ready) begin
        pending = 1'b0;
      end else if (!pending && req_valid) begin
        pending   = 1'b1;
        committed = 1'b0;
        acc_c     = cyc;
        p_we      = req_we;
        p_addr    = req_addr;
        p_wdata   = req_wdata;
        p_size    = req_size;
      end
      if (pending && !committed && cyc == acc_c + WAITC) begin
        mdl_exec(p_we, p_addr, p_wdata, p_size, exp_rdata, exp_err);
        committed = 1'b1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      mon_ev = pending && (cyc >= acc_c + 1 + WAITC);
      chk("mon_req_ready", req_ready, !pending);
      chk("mon_resp_valid", resp_valid, mon_ev);
      if (mon_ev) begin
        chk("mon_resp_rdata", resp_rdata, exp_rdata);
        chk("mon_resp_err", resp_err, exp_err);
      end
    end
  end

  task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 60);
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no resp_valid after %0d cycles, required within %0d", lat, 1 + WAITC);
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_ready) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the response handshake edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=0 for %0d cycles, required 1", n);
      req_valid = 1'b0;
      rd = '0;
      er = 1'b0;
      lat = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_size   = 3'($urandom_range(0, 7));
    resp_ready = 1'($urandom_range(0, 1));
    wait_resp(rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;

    for (int w = 0; w < 64; w++) begin
      do_req(1'b1, 32'(w * 4), (w == 8) ? 32'h5555_5555 : $urandom, 3'b010, rd, er, lat);
      chk("preload_err", er, 0);
    end

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd, er, lat);
    chk("sw_err", er, 0);
    chk("sw_rdata", rd, 0);
    chk("sw_latency", lat, 3);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_err", er, 0);
    chk("lw_latency", lat, 3);

    do_req(1'b1, 32'h13, 32'h0000_00A5, 3'b000, rd, er, lat);
    do_req(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    do_req(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
    chk("lbu_rdata", rd, 32'h0000_00A5);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_sb", rd, 32'hA5AD_BEEF);
    do_req(1'b1, 32'h10, 32'h0000_1234, 3'b001, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_sh", rd, 32'hA5AD_1234);
    do_req(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
    chk("lhu_rdata", rd, 32'h0000_A5AD);
    do_req(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFF_A5AD);

    do_req(1'b0, 32'h11, 32'h0, 3'b001, rd, er, lat);
    chk("lh_mis_err", er, 1);
    chk("lh_mis_rdata", rd, 0);
    do_req(1'b1, 32'h11, 32'h1111_1111, 3'b010, rd, er, lat);
    chk("sw_mis_err", er, 1);
    chk("sw_mis_latency", lat, 3);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_mis", rd, 32'hA5AD_1234);

    do_req(1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
    chk("oob_err", er, 1);
    do_req(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
    chk("size011_err", er, 1);
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, rd, er, lat);
    chk("sbu_err", er, 1);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_sbu", rd, 32'hA5AD_1234);

    // Back-pressure with a second request waiting behind the first.
    resp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    req_addr = 32'h13; req_size = 3'b100;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 60);
    chk("bp_first_valid", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_rdata", resp_rdata, 32'hA5AD_1234);
      chk("bp_hold_err", resp_err, 0);
      chk("bp_hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accept", req_ready, 0);
    wait_resp(rd, er, lat);
    chk("bp_second_rdata", rd, 32'h0000_00A5);

    // Reset during the wait states of a store.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BAD_F00D; req_size = 3'b010;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rs_wait_ready", req_ready, 0);
    reset = 1'b1;
    #1;
    chk("rs_async_valid", resp_valid, 0);
    chk("rs_async_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    chk("rs_lw_rdata", rd, 32'h5555_5555);
    chk("rs_lw_err", er, 0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 255));
      if (r == 0) a = $urandom;
      if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), rd, er, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
